// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and flag indices for alu_seq
// Purpose: constants shared by alu_core, alu_seq and their testbench.
// Ports: none (package).
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'd0;
   localparam logic [3:0] ALU_OR    = 4'd1;
   localparam logic [3:0] ALU_ADD   = 4'd2;
   localparam logic [3:0] ALU_SUB   = 4'd3;
   localparam logic [3:0] ALU_NOTA  = 4'd4;
   localparam logic [3:0] ALU_NOTB  = 4'd5;
   localparam logic [3:0] ALU_INC   = 4'd6;
   localparam logic [3:0] ALU_DEC   = 4'd7;
   localparam logic [3:0] ALU_SLL   = 4'd8;
   localparam logic [3:0] ALU_SRL   = 4'd9;
   localparam logic [3:0] ALU_SRA   = 4'd10;
   localparam logic [3:0] ALU_XOR   = 4'd11;
   localparam logic [3:0] ALU_SLT   = 4'd12;
   localparam logic [3:0] ALU_SLTU  = 4'd13;
   localparam logic [3:0] ALU_PASSA = 4'd14;
   localparam logic [3:0] ALU_RSVD  = 4'd15;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_NEG   = 1;
   localparam int FLAG_CARRY = 2;
   localparam int FLAG_OVF   = 3;
   localparam int NUM_FLAGS  = 4;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational result/carry/overflow for single-cycle ALU ops
// Purpose: one-cycle datapath of alu_seq. Shift opcodes pass A through
//          unchanged (the zero-distance case); real shifts are iterated
//          by alu_seq.
// Ports:
//   a_i, b_i     operands
//   op_i         opcode
//   result_o     combinational result
//   carry_o      adder carry-out (ADD/SUB/INC/DEC), else 0
//   overflow_o   signed overflow (ADD/SUB/INC/DEC), else 0
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o,
   output logic             overflow_o
);

   logic [WIDTH-1:0] add_y;
   logic             add_cin;
   logic [WIDTH:0]   sum;
   logic             is_arith;
   logic             slt_bit;
   logic             sltu_bit;

   // A single adder serves all four arithmetic ops: SUB is A+~B+1,
   // INC is A+0+1, DEC is A+all-ones (i.e. A-1 with carry = no borrow).
   always_comb begin
      add_y    = b_i;
      add_cin  = 1'b0;
      is_arith = 1'b1;
      case (op_i)
         ALU_ADD: begin add_y = b_i;          add_cin = 1'b0; end
         ALU_SUB: begin add_y = ~b_i;         add_cin = 1'b1; end
         ALU_INC: begin add_y = '0;           add_cin = 1'b1; end
         ALU_DEC: begin add_y = '1;           add_cin = 1'b0; end
         default: is_arith = 1'b0;
      endcase
   end

   assign sum      = {1'b0, a_i} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
   assign slt_bit  = $signed(a_i) < $signed(b_i);
   assign sltu_bit = a_i < b_i;

   always_comb begin
      result_o   = '0;
      carry_o    = 1'b0;
      overflow_o = 1'b0;
      case (op_i)
         ALU_AND:   result_o = a_i & b_i;
         ALU_OR:    result_o = a_i | b_i;
         ALU_XOR:   result_o = a_i ^ b_i;
         ALU_NOTA:  result_o = ~a_i;
         ALU_NOTB:  result_o = ~b_i;
         ALU_PASSA: result_o = a_i;
         ALU_SLL, ALU_SRL, ALU_SRA: result_o = a_i;
         ALU_SLT:   result_o = {{(WIDTH-1){1'b0}}, slt_bit};
         ALU_SLTU:  result_o = {{(WIDTH-1){1'b0}}, sltu_bit};
         ALU_RSVD:  result_o = '0;
         default:   result_o = sum[WIDTH-1:0];
      endcase
      if (is_arith) begin
         carry_o    = sum[WIDTH];
         // Same-sign inputs to the adder producing a different-sign sum.
         overflow_o = (a_i[WIDTH-1] == add_y[WIDTH-1]) &&
                      (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative shifter and output register
// Purpose: accepts one op per cycle, holds result/flags until consumed,
//          and runs non-zero shifts one bit per cycle.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operation handshake (a, b, alu_ctrl)
//   out_valid, out_ready result handshake
//   result, zero, negative, carry, overflow   registered result and flags
//   busy                 iterative shift in progress
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t               state_q;
   logic [3:0]           op_q;
   logic [SHW-1:0]       cnt_q;
   logic [WIDTH-1:0]     work_q, work_d;
   logic                 sout_d;
   logic [WIDTH-1:0]     result_q;
   logic [NUM_FLAGS-1:0] flags_q, flags_d, shflags_d;
   logic                 out_valid_q;

   logic [WIDTH-1:0]     core_res;
   logic                 core_c, core_v;
   logic [SHW-1:0]       shamt;
   logic                 accept;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a_i        (a),
      .b_i        (b),
      .op_i       (alu_ctrl),
      .result_o   (core_res),
      .carry_o    (core_c),
      .overflow_o (core_v)
   );

   assign shamt    = b[SHW-1:0];
   assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // One-bit shift step; sout_d is the bit leaving the word this cycle.
   always_comb begin
      work_d = work_q;
      sout_d = 1'b0;
      case (op_q)
         ALU_SLL: begin work_d = {work_q[WIDTH-2:0], 1'b0};     sout_d = work_q[WIDTH-1]; end
         ALU_SRL: begin work_d = {1'b0, work_q[WIDTH-1:1]};     sout_d = work_q[0];       end
         default: begin work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; sout_d = work_q[0]; end
      endcase
   end

   always_comb begin
      flags_d = '0;
      if (alu_ctrl != ALU_RSVD) begin
         flags_d[FLAG_ZERO]  = (core_res == '0);
         flags_d[FLAG_NEG]   = core_res[WIDTH-1];
         flags_d[FLAG_CARRY] = core_c;
         flags_d[FLAG_OVF]   = core_v;
      end
      shflags_d             = '0;
      shflags_d[FLAG_ZERO]  = (work_d == '0);
      shflags_d[FLAG_NEG]   = work_d[WIDTH-1];
      shflags_d[FLAG_CARRY] = sout_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         cnt_q       <= '0;
         work_q      <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // Consumed results drop out_valid unless a new one loads below.
         if (out_ready) out_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_shift(alu_ctrl) && (shamt != '0)) begin
                     op_q    <= alu_ctrl;
                     work_q  <= a;
                     cnt_q   <= shamt;
                     state_q <= ST_SHIFT;
                  end else begin
                     result_q    <= core_res;
                     flags_q     <= flags_d;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               work_q <= work_d;
               cnt_q  <= cnt_q - SHW'(1);
               // Output slot is already free: acceptance required it.
               if (cnt_q == SHW'(1)) begin
                  result_q    <= work_d;
                  flags_q     <= shflags_d;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = flags_q[FLAG_ZERO];
   assign negative  = flags_q[FLAG_NEG];
   assign carry     = flags_q[FLAG_CARRY];
   assign overflow  = flags_q[FLAG_OVF];
   assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a result scoreboard
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [3:0]   alu_ctrl = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, zero, negative, carry, overflow, busy;
   logic [W-1:0] result;
   logic [3:0]   dut_f;

   int total = 0;
   int bad = 0;
   int waits = 0;
   logic [W+3:0] sb[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero),
      .negative(negative), .carry(carry), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   assign dut_f[FLAG_ZERO]  = zero;
   assign dut_f[FLAG_NEG]   = negative;
   assign dut_f[FLAG_CARRY] = carry;
   assign dut_f[FLAG_OVF]   = overflow;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] fl(input logic z, input logic n, input logic c, input logic v);
      fl = '0;
      fl[FLAG_ZERO] = z; fl[FLAG_NEG] = n; fl[FLAG_CARRY] = c; fl[FLAG_OVF] = v;
   endfunction

   // Reference: 17-bit unsigned sums for carry, integer sums for overflow.
   function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      logic [W:0]   s;
      logic         c, v;
      int           sx, sy, si, n;
      r = '0; s = '0; c = 1'b0; v = 1'b0; si = 0;
      sx = int'($signed(x)); sy = int'($signed(y)); n = int'(y[3:0]);
      case (op)
         ALU_AND:   r = x & y;
         ALU_OR:    r = x | y;
         ALU_XOR:   r = x ^ y;
         ALU_NOTA:  r = ~x;
         ALU_NOTB:  r = ~y;
         ALU_PASSA: r = x;
         ALU_ADD:   begin s = {1'b0, x} + {1'b0, y};           si = sx + sy; end
         ALU_SUB:   begin s = {1'b0, x} + {1'b0, ~y} + 17'd1;  si = sx - sy; end
         ALU_INC:   begin s = {1'b0, x} + 17'd1;               si = sx + 1;  end
         ALU_DEC:   begin s = {1'b0, x} + 17'h0FFFF;           si = sx - 1;  end
         ALU_SLT:   r = (sx < sy) ? 16'd1 : 16'd0;
         ALU_SLTU:  r = (x < y) ? 16'd1 : 16'd0;
         ALU_SLL:   begin r = x << n; c = (n == 0) ? 1'b0 : x[W-n]; end
         ALU_SRL:   begin r = x >> n; c = (n == 0) ? 1'b0 : x[n-1]; end
         ALU_SRA:   begin r = W'($signed(x) >>> n); c = (n == 0) ? 1'b0 : x[n-1]; end
         default:   return '0;
      endcase
      if (op == ALU_ADD || op == ALU_SUB || op == ALU_INC || op == ALU_DEC) begin
         r = s[W-1:0];
         c = s[W];
         v = (si > 32767) || (si < -32768);
      end
      return {fl(r == '0, r[W-1], c, v), r};
   endfunction

   // Scoreboard consumer: a result leaves whenever out_valid && out_ready.
   always begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 64'(result), 64'hDEAD_0000_0000_0000);
         end else begin
            logic [W+3:0] e;
            e = sb.pop_front();
            chk("sb_result", 64'(result), 64'(e[W-1:0]));
            chk("sb_flags", 64'(dut_f), 64'(e[W+3:W]));
         end
      end
   end

   // Present an op, wait (bounded) for in_ready, step past the accept edge.
   task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
      int n;
      n = 0;
      alu_ctrl = op; a = x; b = y; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      waits += n;
      if (n >= 100) begin
         total++;
         bad++;
         $error("FAIL accept_timeout observed=%0d expected=<100", n);
      end else if (push) begin
         sb.push_back(model(op, x, y));
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_flags", 64'(dut_f), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      send(ALU_ADD, 16'h7FFF, 16'h0001, 1'b1);
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_result", 64'(result), 64'h8000);
      chk("add_flags", 64'(dut_f), 64'(fl(1'b0, 1'b1, 1'b0, 1'b1)));
      send(ALU_SUB, 16'h0005, 16'h0005, 1'b1);
      chk("sub_result", 64'(result), 64'h0000);
      chk("sub_flags", 64'(dut_f), 64'(fl(1'b1, 1'b0, 1'b1, 1'b0)));
      send(ALU_SLT, 16'hFFFF, 16'h0001, 1'b1);
      chk("slt_result", 64'(result), 64'h0001);
      send(ALU_SLTU, 16'hFFFF, 16'h0001, 1'b1);
      chk("sltu_result", 64'(result), 64'h0000);

      send(ALU_SRA, 16'h8001, 16'h0003, 1'b1);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sra_busy", 64'(busy), 64'd1);
         chk("sra_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      chk("sra_busy_done", 64'(busy), 64'd0);
      chk("sra_valid", 64'(out_valid), 64'd1);
      chk("sra_result", 64'(result), 64'hF000);
      chk("sra_carry", 64'(carry), 64'd0);

      send(ALU_SRL, 16'h0003, 16'h0002, 1'b1);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("srl_result", 64'(result), 64'h0000);
      chk("srl_zero", 64'(zero), 64'd1);
      chk("srl_carry", 64'(carry), 64'd1);

      send(ALU_SLL, 16'h8001, 16'h0011, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("sll_result", 64'(result), 64'h0002);
      chk("sll_carry", 64'(carry), 64'd1);

      @(negedge clk);
      out_ready = 1'b0;
      send(ALU_ADD, 16'h0001, 16'h0002, 1'b1);
      alu_ctrl = ALU_XOR; a = 16'h00F0; b = 16'h0F0F; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_result", 64'(result), 64'h0003);
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(ALU_XOR, 16'h00F0, 16'h0F0F, 1'b1);
      chk("bp_second_valid", 64'(out_valid), 64'd1);
      chk("bp_second_result", 64'(result), 64'h0FFF);

      send(ALU_SLL, 16'h1234, 16'h000F, 1'b0);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      repeat (16) @(negedge clk);
      chk("abort_no_stale", 64'(out_valid), 64'd0);

      send(ALU_SLL, 16'hA5A5, 16'h0010, 1'b1);
      chk("sll0_valid", 64'(out_valid), 64'd1);
      chk("sll0_busy", 64'(busy), 64'd0);
      chk("sll0_result", 64'(result), 64'hA5A5);
      chk("sll0_carry", 64'(carry), 64'd0);
      send(ALU_RSVD, 16'h0000, 16'h0000, 1'b1);
      chk("rsvd_result", 64'(result), 64'd0);
      chk("rsvd_flags", 64'(dut_f), 64'd0);

      waits = 0;
      for (int i = 0; i < 100; i++) begin
         logic [3:0]   op;
         logic [W-1:0] x, y;
         op = 4'($urandom_range(0, 15));
         x  = W'($urandom);
         y  = W'($urandom);
         if (is_shift(op)) y[3:0] = 4'd0;
         send(op, x, y, 1'b1);
      end
      in_valid = 1'b0;
      chk("stream_stalls", 64'(waits), 64'd0);
      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
